// File: rtl/deinterleaver_sub.sv
// rtl/deinterleaver_sub.sv - block de-interleaver: column-major symbols in, row-major symbols out
module deinterleaver_sub #(
    parameter int row = 512,
    parameter int col = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_axis_tdata,
    input  logic s_axis_tvalid,
    input  logic s_axis_tlast,
    output logic s_axis_tready,
    output logic m_axis_tdata,
    output logic m_axis_tvalid,
    output logic m_axis_tlast,
    input  logic m_axis_tready,
    output logic tlast_err
);
    localparam int N  = row * col;
    localparam int RW = $clog2(row) + 1;
    localparam int CW = $clog2(col) + 1;
    localparam int AW = $clog2(N);
    localparam int OW = $clog2(N) + 1;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] in_r_q, in_r_d;
    logic [CW-1:0] in_c_q, in_c_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic          s_tready_q, s_tready_d;
    logic          m_tdata_q, m_tdata_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic          tlast_err_q, tlast_err_d;

    // One block of symbols; contents are don't-care after reset.
    logic          mem [N];

    logic          in_fire;
    logic          in_last_beat;
    logic          in_row_wrap;
    logic [AW:0]   wr_addr;
    logic [AW-1:0] rd_addr;
    logic          rd_data;

    assign s_axis_tready = s_tready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign tlast_err     = tlast_err_q;

    // tready is only ever high in FILL, so a handshake implies FILL.
    assign in_fire      = s_axis_tvalid && s_tready_q;
    assign in_row_wrap  = (in_r_q == RW'(row - 1));
    assign in_last_beat = in_row_wrap && (in_c_q == CW'(col - 1));

    // Column-major beat (in_r, in_c) lands at its row-major position.
    assign wr_addr = (AW+1)'(in_r_q) * (AW+1)'(col) + (AW+1)'(in_c_q);

    // out_cnt is cleared on FILL exit, so it addresses mem[0] on the first DRAIN cycle.
    assign rd_addr = out_cnt_q[AW-1:0];
    assign rd_data = mem[rd_addr];

    // Block memory write port.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_addr[AW-1:0]] <= s_axis_tdata;
        end
    end

    // Next-state logic for the FILL/DRAIN sequencer, counters and stream outputs.
    always_comb begin
        state_d     = state_q;
        in_r_d      = in_r_q;
        in_c_d      = in_c_q;
        out_cnt_d   = out_cnt_q;
        s_tready_d  = s_tready_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        tlast_err_d = 1'b0;

        // Upstream tlast is only audited; framing always follows the beat count.
        if (in_fire) begin
            tlast_err_d = (s_axis_tlast != in_last_beat);
        end

        case (state_q)
            ST_FILL: begin
                s_tready_d = 1'b1;
                m_tvalid_d = 1'b0;
                m_tlast_d  = 1'b0;
                if (in_fire) begin
                    if (in_last_beat) begin
                        s_tready_d = 1'b0;
                        state_d    = ST_DRAIN;
                        in_r_d     = '0;
                        in_c_d     = '0;
                        out_cnt_d  = '0;
                    end else if (in_row_wrap) begin
                        in_r_d = '0;
                        in_c_d = in_c_q + CW'(1);
                    end else begin
                        in_r_d = in_r_q + RW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                s_tready_d = 1'b0;
                if (!m_tvalid_q) begin
                    // First DRAIN cycle: present mem[0].
                    m_tdata_d  = rd_data;
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = 1'b0;
                    out_cnt_d  = OW'(1);
                end else if (m_axis_tready) begin
                    if (m_tlast_q) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        s_tready_d = 1'b1;
                        out_cnt_d  = '0;
                        state_d    = ST_FILL;
                    end else begin
                        m_tdata_d = rd_data;
                        m_tlast_d = (out_cnt_q == OW'(N - 1));
                        out_cnt_d = out_cnt_q + OW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State and output registers; reset clears outputs and discards any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            in_r_q      <= '0;
            in_c_q      <= '0;
            out_cnt_q   <= '0;
            s_tready_q  <= 1'b0;
            m_tdata_q   <= 1'b0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            tlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_r_q      <= in_r_d;
            in_c_q      <= in_c_d;
            out_cnt_q   <= out_cnt_d;
            s_tready_q  <= s_tready_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            tlast_err_q <= tlast_err_d;
        end
    end

endmodule

// File: tb/tb_deinterleaver_sub.sv
// tb/tb_deinterleaver_sub.sv - scoreboard bench for deinterleaver_sub
module tb_deinterleaver_sub;
    localparam int ROW = 4;
    localparam int COL = 3;
    localparam int N   = ROW * COL;

    logic clk = 1'b0;
    logic rst_n;
    logic s_tdata, s_tvalid, s_tlast, s_tready;
    logic m_tdata, m_tvalid, m_tlast, m_tready;
    logic tlast_err;

    always #5 clk = ~clk;

    deinterleaver_sub #(.row(ROW), .col(COL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .tlast_err     (tlast_err)
    );

    typedef struct packed {
        logic d;
        logic l;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];
    exp_t e;
    int   in_j = 0, out_idx = 0, lat = 0;
    int   n_err_seen = 0, n_tlast_seen = 0;
    logic err_pend = 1'b0, prev_stall = 1'b0, prev_d = 1'b0, prev_l = 1'b0;
    int   stall_at = -1, stall_cnt = 3;
    bit   rnd_ready = 1'b0;
    bit   use_gaps = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: fill a row x col matrix column by column, read it back row by row.
    task automatic push_expected(input logic [N-1:0] x);
        logic a [ROW][COL];
        exp_t t;
        for (int c = 0; c < COL; c++)
            for (int r = 0; r < ROW; r++)
                a[r][c] = x[c*ROW + r];
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                t.d = a[r][c];
                t.l = (r == ROW-1) && (c == COL-1);
                sb.push_back(t);
            end
    endtask

    task automatic send_block(input logic [N-1:0] x, input logic [N-1:0] lastv);
        bit ok;
        int w;
        push_expected(x);
        for (int j = 0; j < N; j++) begin
            if (use_gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_tvalid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_tvalid = 1'b1;
            s_tdata  = x[j];
            s_tlast  = lastv[j];
            ok = 1'b0;
            w  = 0;
            while (!ok) begin
                @(negedge clk);
                ok = s_tready;
                @(posedge clk); #1;
                w++;
                if (!ok && w > 200) begin
                    chk("input_accept_timeout", 0, 1);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_complete_remaining", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    // Downstream ready: stall at a chosen output index, random, or always ready.
    initial m_tready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (stall_cnt < 3 && out_idx == stall_at && m_tvalid) begin
            m_tready = 1'b0;
            stall_cnt++;
        end else if (rnd_ready) begin
            m_tready = ($urandom_range(0, 3) != 0);
        end else begin
            m_tready = 1'b1;
        end
    end

    // Monitor: sampled mid-cycle, so valid&&ready here is the handshake at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_j       = 0;
            out_idx    = 0;
            lat        = 0;
            err_pend   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("tlast_err", tlast_err, err_pend);
            if (tlast_err) n_err_seen++;
            if (lat == 1) begin
                chk("latency_edge1_tvalid", m_tvalid, 0);
                lat = 2;
            end else if (lat == 2) begin
                chk("latency_edge2_tvalid", m_tvalid, 1);
                lat = 0;
            end
            if (prev_stall) begin
                chk("stall_hold_tvalid", m_tvalid, 1);
                chk("stall_hold_tdata", m_tdata, prev_d);
                chk("stall_hold_tlast", m_tlast, prev_l);
            end
            if (m_tvalid) chk("drain_s_tready_low", s_tready, 0);
            err_pend = 1'b0;
            if (s_tvalid && s_tready) begin
                err_pend = (s_tlast != (in_j == N-1));
                if (in_j == N-1) begin
                    in_j = 0;
                    lat  = 1;
                end else begin
                    in_j++;
                end
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("out%0d_tdata", out_idx), m_tdata, e.d);
                    chk($sformatf("out%0d_tlast", out_idx), m_tlast, e.l);
                end
                if (m_tlast) n_tlast_seen++;
                out_idx = m_tlast ? 0 : out_idx + 1;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] v, lv, norm_last;
        int w, base;
        norm_last = '0;
        norm_last[N-1] = 1'b1;
        rst_n = 1'b0; s_tdata = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_s_tready", s_tready, 0);
        chk("reset_m_tvalid", m_tvalid, 0);
        chk("reset_m_tdata", m_tdata, 0);
        chk("reset_m_tlast", m_tlast, 0);
        chk("reset_tlast_err", tlast_err, 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_s_tready", s_tready, 1);

        // Single 1 at beat 1 -> output index 3
        v = '0; v[1] = 1'b1;
        send_block(v, norm_last);
        wait_drain();

        // Single 1 at beat 4 -> index 1, then single 1 at beat 11 -> index 11
        v = '0; v[4] = 1'b1;
        send_block(v, norm_last);
        wait_drain();
        v = '0; v[11] = 1'b1;
        send_block(v, norm_last);
        wait_drain();

        // Back-pressure at output index 5
        v = N'($urandom);
        stall_at = 5; stall_cnt = 0;
        send_block(v, norm_last);
        wait_drain();
        chk("stall_cycles_applied", stall_cnt, 3);
        stall_at = -1;

        // Misplaced tlast on beats 5 and 11
        base = n_err_seen;
        v = N'($urandom);
        lv = '0; lv[5] = 1'b1;
        send_block(v, lv);
        wait_drain();
        chk("tlast_err_pulse_count", n_err_seen - base, 2);

        // Reset mid-drain after output index 6
        v = N'($urandom);
        send_block(v, norm_last);
        w = 0;
        while (out_idx != 7 && w < 100) begin
            @(posedge clk);
            w++;
        end
        chk("reached_output_7", out_idx, 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_m_tvalid", m_tvalid, 0);
        chk("midreset_m_tdata", m_tdata, 0);
        chk("midreset_m_tlast", m_tlast, 0);
        chk("midreset_s_tready", s_tready, 0);
        chk("midreset_tlast_err", tlast_err, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        chk("release_s_tready_before_edge", s_tready, 0);
        @(posedge clk); #1;
        chk("release_s_tready_after_edge", s_tready, 1);
        v = N'($urandom);
        send_block(v, norm_last);
        wait_drain();

        // Randomized blocks with input gaps and random downstream ready
        base = n_tlast_seen;
        rnd_ready = 1'b1;
        use_gaps  = 1'b1;
        for (int b = 0; b < 6; b++) begin
            v = N'($urandom);
            send_block(v, norm_last);
        end
        wait_drain();
        chk("random_tlast_count", n_tlast_seen - base, 6);
        rnd_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
